// File: rtl/uart_rx_param_pkg.sv
// rtl/uart_rx_param_pkg.sv - shared UART receiver defaults, parity encodings and FSM state type
`ifndef UART_BIT_DURATION
`define UART_BIT_DURATION 16
`endif
`ifndef UART_PARITY_NONE
`define UART_PARITY_NONE 0
`define UART_PARITY_ODD  1
`define UART_PARITY_EVEN 2
`endif

package uart_rx_param_pkg;
    localparam int UART_CPB_DEFAULT = `UART_BIT_DURATION;
    localparam int PAR_NONE = `UART_PARITY_NONE;
    localparam int PAR_ODD  = `UART_PARITY_ODD;
    localparam int PAR_EVEN = `UART_PARITY_EVEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } rx_state_t;

    // Odd mode wants data^parity == 1, even mode wants it == 0.
    function automatic logic parity_bad(input logic data_xor, input logic par_bit, input int mode);
        logic w_x;
        w_x = data_xor ^ par_bit;
        if (mode == PAR_ODD)
            return ~w_x;
        else if (mode == PAR_EVEN)
            return w_x;
        else
            return 1'b0;
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO; push into a full FIFO only succeeds alongside a pop
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_full  = (r_count == FULL_CNT);
    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop && o_valid;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_push;
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers are log2(DEPTH) wide, so natural overflow wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with mid-bit sampling, error flags and receive FIFO
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CPB_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int FW = DATA_BITS + 2;
    localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2, r_prev;
    logic [1:0]           r_warm;
    rx_state_t            r_state, w_state_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par_bit, w_par_bit_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 r_push, w_push_nxt;
    logic [FW-1:0]        r_push_word, w_push_word_nxt;
    logic                 r_break, w_break_nxt;
    logic                 r_overrun;
    logic                 w_rx, w_fall, w_tick, w_drop, w_pop;
    logic [FW-1:0]        w_head;

    // Edge detection is armed only once r_prev holds a real line sample, so a
    // line already low at reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_warm  <= 2'd0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = (r_warm == 2'd3) && r_prev && !r_sync2;
    assign w_tick = (r_timer == TW'(1));

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_par_bit_nxt   = r_par_bit;
        w_ferr_nxt      = r_ferr;
        w_push_nxt      = 1'b0;
        w_push_word_nxt = r_push_word;
        w_break_nxt     = 1'b0;
        if (r_state != S_IDLE && r_state != S_BRK_WAIT && !w_tick)
            w_timer_nxt = r_timer - 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_timer_nxt   = T_HALF;
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = '0;
                    w_par_bit_nxt = 1'b0;
                    w_ferr_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_timer_nxt = T_FULL;
                    w_state_nxt = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rx, r_shift[DATA_BITS-1:1]};
                    w_timer_nxt = T_FULL;
                    if (r_bit_cnt == LAST_DATA) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_par_bit_nxt = w_rx;
                    w_timer_nxt   = T_FULL;
                    w_state_nxt   = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_bit_cnt == 3'd0 && !w_rx && r_shift == '0 &&
                        (PARITY == PAR_NONE || !r_par_bit)) begin
                        w_break_nxt = 1'b1;
                        w_state_nxt = S_BRK_WAIT;
                    end else begin
                        w_ferr_nxt = r_ferr | !w_rx;
                        if (r_bit_cnt == LAST_STOP) begin
                            w_push_nxt      = 1'b1;
                            w_push_word_nxt = {parity_bad(^r_shift, r_par_bit, PARITY),
                                               r_ferr | !w_rx, r_shift};
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                            w_timer_nxt   = T_FULL;
                        end
                    end
                end
            end
            S_BRK_WAIT: begin
                if (w_rx)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_word <= '0;
            r_break     <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_bit   <= w_par_bit_nxt;
            r_ferr      <= w_ferr_nxt;
            r_push      <= w_push_nxt;
            r_push_word <= w_push_word_nxt;
            r_break     <= w_break_nxt;
            r_overrun   <= w_drop;
        end
    end

    assign w_pop = rx_valid && rx_ready;

    uart_rx_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (r_push),
        .i_push_data(r_push_word),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_valid    (rx_valid),
        .o_drop     (w_drop)
    );

    assign rx_data    = w_head[DATA_BITS-1:0];
    assign frame_err  = w_head[DATA_BITS];
    assign parity_err = w_head[DATA_BITS+1];
    assign overrun    = r_overrun;
    assign break_det  = r_break;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized and directed bench for uart_rx_param (8N1, 7E1, 8N2 instances)
module tb_uart_rx_param;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] line;
    logic [2:0] ready = 3'b000;
    wire  [2:0] valid, pe, fe, ovr, brk, busy;
    wire  [7:0] d0, d2;
    wire  [6:0] d1;

    int cyc = 0, n_checks = 0, n_err = 0, c_start = 0;
    int ready_mode[3], exp_ovr[3], exp_brk[3], ovr_cnt[3], brk_cnt[3], pops[3], rise_cyc[3];
    int mhead[3], mtail[3];
    logic [9:0] mbuf[3][16];
    logic [2:0] vprev = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .serial_in(line[0]), .rx_data(d0), .rx_valid(valid[0]),
        .rx_ready(ready[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]),
        .break_det(brk[0]), .busy(busy[0]));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7e1 (
        .clk(clk), .reset_n(reset_n), .serial_in(line[1]), .rx_data(d1), .rx_valid(valid[1]),
        .rx_ready(ready[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]),
        .break_det(brk[1]), .busy(busy[1]));
    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
        .clk(clk), .reset_n(reset_n), .serial_in(line[2]), .rx_data(d2), .rx_valid(valid[2]),
        .rx_ready(ready[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]),
        .break_det(brk[2]), .busy(busy[2]));

    function automatic int nbits(int i); return (i == 1) ? 7 : 8; endfunction
    function automatic int pmode(int i); return (i == 1) ? 2 : 0; endfunction
    function automatic int nstop(int i); return (i == 2) ? 2 : 1; endfunction

    function automatic logic [9:0] got_word(int i);
        case (i)
            0:       return {pe[0], fe[0], d0};
            1:       return {pe[1], fe[1], 1'b0, d1};
            default: return {pe[2], fe[2], d2};
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mhead[i] = 0; mtail[i] = 0; exp_ovr[i] = 0; exp_brk[i] = 0;
        end
    endtask

    // Expected outcome of one frame, straight from the line-level frame content.
    task automatic model_frame(input int i, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        logic [7:0] dm;
        logic       x, pe_e, fe_e;
        dm = d & 8'((1 << nbits(i)) - 1);
        x  = (^dm) ^ pbit;
        if (dm == 8'd0 && (pmode(i) == 0 || !pbit) && !stops[0]) begin
            exp_brk[i]++;
        end else begin
            pe_e = (pmode(i) == 1) ? !x : (pmode(i) == 2) ? x : 1'b0;
            fe_e = !stops[0] || (nstop(i) == 2 && !stops[1]);
            if (mtail[i] - mhead[i] >= 4) begin
                exp_ovr[i]++;
            end else begin
                mbuf[i][mtail[i] % 16] = {pe_e, fe_e, dm};
                mtail[i]++;
            end
        end
    endtask

    task automatic drive(input int i, input logic v);
        line[i] = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [7:0] d, input logic pbit, input logic [1:0] stops);
        model_frame(i, d, pbit, stops);
        @(posedge clk); #1;
        c_start = cyc;
        drive(i, 1'b0);
        for (int b = 0; b < nbits(i); b++) drive(i, d[b]);
        if (pmode(i) != 0) drive(i, pbit);
        drive(i, stops[0]);
        if (nstop(i) == 2) drive(i, stops[1]);
        line[i] = 1'b1;
    endtask

    // Compare process: every cycle, head of each DUT FIFO against the model queue.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (valid[i] && !vprev[i]) rise_cyc[i] = cyc;
                vprev[i] = valid[i];
                if (valid[i]) begin
                    n_checks++;
                    if (mtail[i] == mhead[i]) begin
                        n_err++;
                        $display("FAIL unexpected_valid inst%0d: got=%h expected no entry", i, got_word(i));
                    end else if (got_word(i) !== mbuf[i][mhead[i] % 16]) begin
                        n_err++;
                        $display("FAIL head_word inst%0d: got=%h expected=%h", i, got_word(i), mbuf[i][mhead[i] % 16]);
                    end
                end
                if (ovr[i]) begin
                    n_checks++; ovr_cnt[i]++;
                    if (exp_ovr[i] == 0) begin
                        n_err++;
                        $display("FAIL overrun inst%0d: got pulse expected none", i);
                    end else exp_ovr[i]--;
                end
                if (brk[i]) begin
                    n_checks++; brk_cnt[i]++;
                    if (exp_brk[i] == 0) begin
                        n_err++;
                        $display("FAIL break_det inst%0d: got pulse expected none", i);
                    end else exp_brk[i]--;
                end
                case (ready_mode[i])
                    0:       ready[i] = 1'b0;
                    1:       ready[i] = 1'($urandom_range(0, 1));
                    default: ready[i] = 1'b1;
                endcase
                if (valid[i] && ready[i]) begin
                    pops[i]++;
                    if (mtail[i] != mhead[i]) mhead[i]++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int         o0, b0, p0, t;
        logic [7:0] d, m;
        logic       pb;
        logic [1:0] st;
        for (int i = 0; i < 3; i++) begin
            ready_mode[i] = 0; ovr_cnt[i] = 0; brk_cnt[i] = 0; pops[i] = 0; rise_cyc[i] = 0;
        end
        model_reset();
        reset_n = 1'b0;
        line    = 3'b111;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", valid[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_word", got_word(i), 0);
        end

        send_frame(0, 8'hA5, 1'b0, 2'b11);
        chk("lat_8n1", rise_cyc[0] - c_start, 156);
        chk("word_8n1_a5", got_word(0), 10'h0A5);
        send_frame(1, 8'h41, 1'b1, 2'b11);
        chk("lat_7e1", rise_cyc[1] - c_start, 156);
        chk("word_7e1_41", got_word(1), 10'h241);
        send_frame(2, 8'h3C, 1'b0, 2'b01);
        chk("lat_8n2", rise_cyc[2] - c_start, 172);
        chk("word_8n2_3c", got_word(2), 10'h13C);
        for (int i = 0; i < 3; i++) ready_mode[i] = 2;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("drained_valid", valid[i], 0);

        @(posedge clk); #1 line[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1 line[0] = 1'b1;
        chk("glitch_busy_high", busy[0], 1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_busy_low", busy[0], 0);
        chk("glitch_no_push", valid[0], 0);

        ready_mode[0] = 0;
        o0 = ovr_cnt[0]; p0 = pops[0];
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(8'h10 + k), 1'b0, 2'b11);
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_pulses", ovr_cnt[0] - o0, 1);
        chk("overrun_full_valid", valid[0], 1);
        chk("overrun_head_frame1", got_word(0), 10'h011);
        ready_mode[0] = 2;
        repeat (10) @(posedge clk);
        #1;
        chk("overrun_pops", pops[0] - p0, 4);
        chk("overrun_empty", valid[0], 0);

        b0 = brk_cnt[0];
        model_frame(0, 8'h00, 1'b0, 2'b00);
        @(posedge clk); #1 line[0] = 1'b0;
        repeat (192) @(posedge clk);
        #1 line[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("break_pulses", brk_cnt[0] - b0, 1);
        chk("break_no_push", valid[0], 0);
        chk("break_idle", busy[0], 0);

        @(posedge clk); #1 line[0] = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("mid_frame_busy", busy[0], 1);
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_valid", valid[i], 0);
            chk("rstmid_busy", busy[i], 0);
            chk("rstmid_word", got_word(i), 0);
            chk("rstmid_pulses", {ovr[i], brk[i]}, 0);
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("low_at_release_not_start", busy[0], 0);
        line[0] = 1'b1;
        repeat (5) @(posedge clk);
        ready_mode[0] = 0;
        send_frame(0, 8'h55, 1'b0, 2'b11);
        chk("post_reset_0x55", got_word(0), 10'h055);
        ready_mode[0] = 2;

        for (int i = 0; i < 3; i++) ready_mode[i] = 1;
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 12; k++) begin
                d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                m  = d & 8'((1 << nbits(i)) - 1);
                pb = ^m;
                if ($urandom_range(0, 3) == 0) pb = ~pb;
                st[0] = ($urandom_range(0, 4) != 0);
                st[1] = ($urandom_range(0, 4) != 0);
                send_frame(i, d, pb, st);
                repeat ($urandom_range(0, 5)) @(posedge clk);
            end
        end

        for (int i = 0; i < 3; i++) ready_mode[i] = 2;
        t = 0;
        while (t < 1000 && (valid != 3'b000 || mtail[0] != mhead[0] || mtail[1] != mhead[1] || mtail[2] != mhead[2])) begin
            @(posedge clk);
            t++;
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("final_model_empty", mtail[i] - mhead[i], 0);
            chk("final_valid", valid[i], 0);
            chk("final_exp_overrun_seen", exp_ovr[i], 0);
            chk("final_exp_break_seen", exp_brk[i], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
